// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU sequencer and its ALU responder.
//   W_DEFAULT  default operand, result and accumulator width
//   OP_*       5-bit ALU opcodes driven on alu_op
//   FLAG_*     bit positions within the 4-bit alu_flags / rsp_flags vectors
//   seq_state_e  sequencer state encoding
`timescale 1ns/1ps
package alu_pkg;

  localparam int W_DEFAULT = 16;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_PASS = 5'b10000;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command at a time, drives it to an external
// ALU, waits a fixed latency, captures the result into an accumulator and
// presents it as a response until the consumer takes it.
//
//   clk, rst_n                   clock, async active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op, cmd_a, cmd_b         opcode and signed operands
//   cmd_use_acc                  take operand A from the accumulator
//   alu_op, operandA, operandB   registered command towards the ALU
//   alu_result, alu_flags        ALU outputs, sampled after ALU_LAT cycles
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_flags        captured result and flags
//   busy                         high whenever not IDLE
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a command; cmd_ready high
// S_ISSUE | operands presented to the ALU; wait counter loaded
// S_WAIT  | counting down ALU latency; sample result at zero
// S_RESP  | rsp_valid high, holding result until rsp_ready
`timescale 1ns/1ps
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [4:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic [4:0]   alu_op,
  output logic [W-1:0] operandA,
  output logic [W-1:0] operandB,
  input  logic [W-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         busy
);

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  seq_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] acc_q, acc_d;
  logic [4:0]   alu_op_q, alu_op_d;
  logic [W-1:0] opa_q, opa_d;
  logic [W-1:0] opb_q, opb_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         busy_q, busy_d;
  logic         accept;

  // cmd_ready is a flop (reset to 0) so it stays low during reset and rises
  // only at the first clock edge after release.
  assign accept = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    alu_op_d     = alu_op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_valid_d  = rsp_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          alu_op_d = cmd_op;
          opa_d    = cmd_use_acc ? acc_q : cmd_a;
          opb_d    = cmd_b;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          acc_d        = alu_result;
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      alu_op_q     <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_valid_q  <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      alu_op_q     <= alu_op_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_valid_q  <= rsp_valid_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_op     = alu_op_q;
  assign operandA   = opa_q;
  assign operandB   = opb_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: one instance with ALU_LAT=1 and one with ALU_LAT=4,
// each answered by a combinational ALU responder. Shared command bus; sel
// routes cmd_valid to one instance and selects whose outputs are observed.
`timescale 1ns/1ps
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         sel;
  logic         cmd_valid, rsp_ready, cmd_use_acc;
  logic [4:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;

  logic         rdy0, rdy1, rv0, rv1, busy0, busy1;
  logic [4:0]   op0, op1;
  logic [W-1:0] opa0, opa1, opb0, opb1, res0, res1, rr0, rr1;
  logic [3:0]   flg0, flg1, rf0, rf1;

  logic         m_ready, m_rv, m_busy;
  logic [4:0]   m_op;
  logic [W-1:0] m_opa, m_opb, m_rr;
  logic [3:0]   m_rf;

  int checks = 0;
  int failures = 0;

  function automatic logic [W+3:0] alu_eval(input logic [4:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [3:0]   f;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_PASS: r = a;
      default: r = '0;
    endcase
    f = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[W-1];
    return {f, r};
  endfunction

  always_comb {flg0, res0} = alu_eval(op0, opa0, opb0);
  always_comb {flg1, res1} = alu_eval(op1, opa1, opb1);

  alu_sequencer #(.W(W), .ALU_LAT(1)) u_seq1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid && !sel), .cmd_ready(rdy0),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_op(op0), .operandA(opa0), .operandB(opb0),
    .alu_result(res0), .alu_flags(flg0),
    .rsp_valid(rv0), .rsp_ready(rsp_ready),
    .rsp_result(rr0), .rsp_flags(rf0), .busy(busy0)
  );

  alu_sequencer #(.W(W), .ALU_LAT(4)) u_seq4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid && sel), .cmd_ready(rdy1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_op(op1), .operandA(opa1), .operandB(opb1),
    .alu_result(res1), .alu_flags(flg1),
    .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_result(rr1), .rsp_flags(rf1), .busy(busy1)
  );

  always_comb begin
    m_ready = sel ? rdy1  : rdy0;
    m_rv    = sel ? rv1   : rv0;
    m_busy  = sel ? busy1 : busy0;
    m_op    = sel ? op1   : op0;
    m_opa   = sel ? opa1  : opa0;
    m_opb   = sel ? opb1  : opb0;
    m_rr    = sel ? rr1   : rr0;
    m_rf    = sel ? rf1   : rf0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transaction with rsp_ready held high; checks accept, latency,
  // operand hold, result and flags. Entered and left just after a posedge.
  task automatic run_txn(input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ua,
                         input logic [W-1:0] exp_opa, input int exp_lat,
                         input logic [W-1:0] exp_res, input logic [3:0] exp_flg,
                         input string tag);
    int lat;
    logic seen, hold_ok;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_ready) begin seen = 1'b1; break; end
    end
    chk({tag, " accept"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 5'h1f; cmd_a = 16'h5a5a; cmd_b = 16'ha5a5; cmd_use_acc = 1'b0;
    lat = 0; seen = 1'b0; hold_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (m_op !== op || m_opa !== exp_opa || m_opb !== b) hold_ok = 1'b0;
      if (m_rv) begin seen = 1'b1; break; end
    end
    chk({tag, " rsp_valid seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " operand hold"}, 32'(hold_ok), 32'd1);
    chk({tag, " rsp_result"}, 32'(m_rr), 32'(exp_res));
    chk({tag, " rsp_flags"}, 32'(m_rf), 32'(exp_flg));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         use_acc;
    logic [W-1:0] exp_res;
    logic [3:0]   exp_flg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [W-1:0] exp_acc;
    logic seen, ok;
    int lat;

    vecs[0]  = '{OP_XOR, -16'sd32,   16'sd5,    1'b0, -16'sd27,  4'b0010};
    vecs[1]  = '{OP_XOR, -16'sd13,  -16'sd3,    1'b0, 16'sd14,   4'b0000};
    vecs[2]  = '{OP_XOR, 16'h7777,   16'sd14,   1'b1, 16'h0000,  4'b0001};
    vecs[3]  = '{OP_XOR, 16'h7777,   16'h1234,  1'b1, 16'h1234,  4'b0000};
    vecs[4]  = '{OP_ADD, 16'sd100,  -16'sd30,   1'b0, 16'sd70,   4'b0000};
    vecs[5]  = '{OP_ADD, 16'h0000,  -16'sd100,  1'b1, -16'sd30,  4'b0010};
    vecs[6]  = '{OP_AND, 16'h0f0f,   16'h00ff,  1'b0, 16'h000f,  4'b0000};
    vecs[7]  = '{OP_OR,  16'h00f0,   16'h0f00,  1'b0, 16'h0ff0,  4'b0000};
    vecs[8]  = '{OP_SUB, 16'sd5,     16'sd7,    1'b0, -16'sd2,   4'b0010};
    vecs[9]  = '{OP_XOR, 16'h1111,  -16'sd2,    1'b1, 16'h0000,  4'b0001};
    vecs[10] = '{OP_ADD, 16'h7fff,   16'h0001,  1'b0, 16'h8000,  4'b0010};
    vecs[11] = '{OP_ADD, 16'hffff,   16'h0001,  1'b0, 16'h0000,  4'b0001};

    sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_use_acc = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;

    // Reset behaviour
    #12;
    chk("reset cmd_ready", 32'(rdy0), 32'd0);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset rsp_valid", 32'(rv0), 32'd0);
    chk("reset operandA", 32'(opa0), 32'd0);
    chk("reset cmd_ready lat4", 32'(rdy1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("cmd_ready before first edge", 32'(rdy0), 32'd0);
    @(negedge clk);
    chk("cmd_ready after first edge", 32'(rdy0), 32'd1);
    @(posedge clk); #1;

    // Table of single transactions on the ALU_LAT=1 instance
    exp_acc = '0;
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_acc,
              vecs[i].use_acc ? exp_acc : vecs[i].a, 3,
              vecs[i].exp_res, vecs[i].exp_flg, $sformatf("vec%0d", i));
      exp_acc = vecs[i].exp_res;
    end

    // Backpressure: response held 5 cycles while a second command waits
    rsp_ready = 1'b0;
    cmd_op = OP_XOR; cmd_a = 16'h0001; cmd_b = 16'h0002; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    chk("bp accept", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    cmd_a = 16'h0010; cmd_b = 16'h0001;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); lat++;
      if (m_rv) begin seen = 1'b1; break; end
    end
    chk("bp latency", 32'(lat), 32'd3);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!m_rv || m_rr !== 16'h0003 || m_rf !== 4'b0000 || m_ready || !m_busy || m_opa !== 16'h0001)
        ok = 1'b0;
    end
    chk("bp hold stable", 32'(ok), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp ready after handshake", 32'(m_ready), 32'd1);
    chk("bp rsp_valid dropped", 32'(m_rv), 32'd0);
    chk("bp second not yet accepted", 32'(m_opa), 32'h0001);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp second accepted", 32'(m_opa), 32'h0010);
    chk("bp busy", 32'(m_busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_rv) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp second rsp_valid", 32'(seen), 32'd1);
    chk("bp second result", 32'(m_rr), 32'h0011);
    @(posedge clk); #1;

    // ALU_LAT=4 instance
    sel = 1'b1;
    run_txn(OP_XOR, 16'd16, 16'd16, 1'b0, 16'd16, 6, 16'h0000, 4'b0001, "lat4");
    run_txn(OP_XOR, 16'h00f0, 16'h0f00, 1'b0, 16'h00f0, 6, 16'h0ff0, 4'b0000, "lat4b");

    // Reset in WAIT aborts the transaction
    cmd_op = OP_XOR; cmd_a = 16'd16; cmd_b = -16'sd10; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    chk("rstwait accept", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstwait busy before reset", 32'(m_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwait busy", 32'(m_busy), 32'd0);
    chk("rstwait cmd_ready", 32'(m_ready), 32'd0);
    chk("rstwait rsp_valid", 32'(m_rv), 32'd0);
    chk("rstwait alu_op", 32'(m_op), 32'd0);
    chk("rstwait operandA", 32'(m_opa), 32'd0);
    chk("rstwait operandB", 32'(m_opb), 32'd0);
    chk("rstwait rsp_result", 32'(m_rr), 32'd0);
    chk("rstwait rsp_flags", 32'(m_rf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_rv) seen = 1'b1;
    end
    chk("rstwait no response", 32'(seen), 32'd0);
    @(posedge clk); #1;
    run_txn(OP_XOR, 16'h7777, 16'd5, 1'b1, 16'h0000, 6, 16'h0005, 4'b0000, "post reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter W, default 16, SHALL set data width of operands, result and accumulator.
REQ-002 Parameter ALU_LAT, default 1, range 1..15, SHALL set the cycles waited after issue before the ALU result is sampled.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-007 cmd_op  input  5  ALU opcode (e.g. 5'b01100 = XOR).
REQ-008 cmd_a, cmd_b  input  W each  signed operands.
REQ-009 cmd_use_acc  input  1  when 1, operandA SHALL come from the accumulator instead of cmd_a.
REQ-010 alu_op  output  5  opcode driven to the ALU.
REQ-011 operandA, operandB  output  W each  operands driven to the ALU.
REQ-012 alu_result  input  W  ALU resultAccumulator.
REQ-013 alu_flags  input  4  ALU flags.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  consumer takes response.
REQ-016 rsp_result  output  W; rsp_flags  output  4  captured result and flags.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-020 On accept: register cmd_op to alu_op, (cmd_use_acc ? acc : cmd_a) to operandA, cmd_b to operandB; go to ISSUE.
REQ-021 alu_op, operandA, operandB SHALL hold stable from the cycle after accept until return to IDLE.
REQ-022 ISSUE SHALL load the wait counter with ALU_LAT-1 and go to WAIT.
REQ-023 WAIT SHALL decrement the counter each cycle; at zero, sample alu_result into acc and rsp_result, alu_flags into rsp_flags, go to RESP.
REQ-024 Accept-to-rsp_valid latency SHALL be ALU_LAT+2 cycles.
REQ-025 RESP SHALL assert rsp_valid and hold rsp_result/rsp_flags stable until rsp_ready=1, then return to IDLE.
REQ-026 rsp_ready asserted outside RESP SHALL be ignored.
REQ-027 cmd_valid during ISSUE/WAIT/RESP SHALL be ignored (not accepted, not lost state); first acceptable cycle after a handshake is the cycle after RESP exits.
REQ-028 Accumulator SHALL be W bits, wrap-around per ALU result; sequencer performs no arithmetic of its own.
REQ-029 cmd_use_acc SHALL read the accumulator value as of the accept cycle, including a value written by the immediately preceding transaction.

Reset
REQ-030 On rst_n=0, immediately: state IDLE, acc=0, alu_op=0, operandA=0, operandB=0, rsp_result=0, rsp_flags=0, rsp_valid=0, busy=0, counter=0.
REQ-031 cmd_ready SHALL be 0 while rst_n=0 and 1 from the first clock edge after release.
REQ-032 Reset during ISSUE/WAIT/RESP SHALL abort the transaction with no response produced.

Structure
REQ-033 Shared package alu_pkg SHALL hold default W, the 5-bit opcode constants (OP_XOR=5'b01100 etc.), flag bit positions and the sequencer state encoding.
REQ-034 No sub-module; the bench SHALL instantiate the existing alu as the responder wired to alu_op/operandA/operandB/alu_result/alu_flags.

Verification
REQ-035 XOR: cmd_a=-32, cmd_b=5, op 01100, ALU_LAT=1 -> rsp_valid 3 cycles after accept, rsp_result=-27.
REQ-036 XOR: cmd_a=-13, cmd_b=-3 -> rsp_result=14; then cmd_use_acc=1, cmd_b=14 -> rsp_result=0, acc=0.
REQ-037 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_result stable, cmd_ready=0, second cmd_valid not accepted until cycle after rsp_ready=1.
REQ-038 ALU_LAT=4: cmd_a=16, cmd_b=16 XOR -> rsp_valid exactly 6 cycles after accept, result 0, operands stable throughout.
REQ-039 Reset in WAIT (cmd_a=16, cmd_b=-10) -> all outputs 0 asynchronously, no rsp_valid after release, next command completes normally.
